// File: rtl/latch_bank_wr_if.sv
// latch_bank_wr_if
// Bundles the request side and the latch-bank side of the latch bank
// write controller into one interface.
//   req       : per-requester write request (level), held until ack
//   req_addr  : packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   ack       : one-cycle completion pulse to the granted requester
//   err       : pulses with ack when the granted address was >= DEPTH
//   latch_en  : one-hot latch enables, zero outside the transparency window
//   latch_d   : shared data bus to every latch D input
//   busy      : controller is in any state other than IDLE
//   gnt_id    : index of the current or most recent grant
// Modports: master = requesting side, slave = controller.
interface latch_bank_wr_if #(
    parameter int NREQ   = 4,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    localparam int GNT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_data;
    logic [NREQ-1:0]        ack;
    logic                   err;
    logic [DEPTH-1:0]       latch_en;
    logic [WIDTH-1:0]       latch_d;
    logic                   busy;
    logic [GNT_W-1:0]       gnt_id;

    modport master (
        output req, req_addr, req_data,
        input  ack, err, latch_en, latch_d, busy, gnt_id
    );

    modport slave (
        input  req, req_addr, req_data,
        output ack, err, latch_en, latch_d, busy, gnt_id
    );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// latch_bank_wr_ctrl
// Round-robin write controller for a bank of level-sensitive latch words.
// Each granted write runs SETUP (data driven, enables low), OPEN (one
// enable high for EN_CYCLES), HOLD (enables low, data held for GUARD
// cycles) and ACK (completion pulse), so at most one latch is transparent
// and latch_d never moves while a latch is open or inside its guard time.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : latch_bank_wr_if slave modport (requests in, latch drive out)
// All outputs on bus are registered.
module latch_bank_wr_ctrl #(
    parameter int NREQ      = 4,
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int EN_CYCLES = 2,
    parameter int GUARD     = 1
) (
    input  logic              clk,
    input  logic              rst,
    latch_bank_wr_if.slave    bus
);
    localparam int GNT_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (EN_CYCLES > GUARD) ? EN_CYCLES : GUARD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_OPEN  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    state_t              state_r;
    logic [GNT_W-1:0]    ptr_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                any_req_s;
    logic [GNT_W-1:0]    sel_s;
    logic                addr_ok_s;
    int                  idx_s;

    // One-hot latch enable for an address; out-of-range addresses give zero.
    function automatic logic [DEPTH-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] v;
        v = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(a) == k) begin
                v[k] = 1'b1;
            end else begin
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    // One-hot acknowledge vector for a grant index.
    function automatic logic [NREQ-1:0] gnt_onehot(input logic [GNT_W-1:0] g);
        logic [NREQ-1:0] v;
        v = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(g) == k) begin
                v[k] = 1'b1;
            end else begin
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    // Round-robin pick: first active request at or after the pointer, wrapping.
    always_comb begin
        any_req_s = 1'b0;
        sel_s     = '0;
        idx_s     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = int'(ptr_r) + i;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            if (!any_req_s && bus.req[idx_s]) begin
                any_req_s = 1'b1;
                sel_s     = GNT_W'(idx_s);
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    // Captured address lands inside the bank.
    assign addr_ok_s = (int'(addr_r) < DEPTH);

    // Transaction sequencer with all bus outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            addr_r       <= '0;
            cnt_r        <= '0;
            bus.ack      <= '0;
            bus.err      <= 1'b0;
            bus.latch_en <= '0;
            bus.latch_d  <= '0;
            bus.busy     <= 1'b0;
            bus.gnt_id   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        // Capture once; later input changes are ignored.
                        state_r     <= ST_SETUP;
                        bus.busy    <= 1'b1;
                        bus.gnt_id  <= sel_s;
                        addr_r      <= bus.req_addr[int'(sel_s)*ADDR_W +: ADDR_W];
                        bus.latch_d <= bus.req_data[int'(sel_s)*WIDTH +: WIDTH];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_OPEN;
                    cnt_r   <= '0;
                    if (addr_ok_s) begin
                        bus.latch_en <= addr_onehot(addr_r);
                    end else begin
                        bus.latch_en <= '0;
                    end
                end
                ST_OPEN: begin
                    if (cnt_r == CNT_W'(EN_CYCLES - 1)) begin
                        state_r      <= ST_HOLD;
                        cnt_r        <= '0;
                        bus.latch_en <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_W'(GUARD - 1)) begin
                        state_r <= ST_ACK;
                        cnt_r   <= '0;
                        bus.ack <= gnt_onehot(bus.gnt_id);
                        bus.err <= ~addr_ok_s;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_ACK: begin
                    // Just-served requester drops to lowest priority.
                    state_r  <= ST_IDLE;
                    bus.ack  <= '0;
                    bus.err  <= 1'b0;
                    bus.busy <= 1'b0;
                    if (bus.gnt_id == GNT_W'(NREQ - 1)) begin
                        ptr_r <= '0;
                    end else begin
                        ptr_r <= bus.gnt_id + 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= '0;
                    bus.ack      <= '0;
                    bus.err      <= 1'b0;
                    bus.latch_en <= '0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/latch_bank_wr_ctrl.md
# latch_bank_wr_ctrl

Write controller and arbiter for a bank of level-sensitive D-latch storage words. Up to NREQ requesters ask to write one word each. The block grants them round-robin and sequences each write as setup, transparency window, and hold guard. It drives a one-hot latch enable and a shared data bus, so only one latch is ever transparent and data is always stable around every enable edge. It sits between requesting logic and the latch bank (one d_latch-style WIDTH-bit word per entry).

## Interface
- NREQ, 4: number of requesters (2..8)
- DEPTH, 8: number of latch words in the bank
- WIDTH, 8: data width per word
- ADDR_W, 3: address width; must be ≥ clog2(DEPTH)
- EN_CYCLES, 2: cycles the selected latch enable is held high (≥1)
- GUARD, 1: cycles data stays stable after the enable falls (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester write request (level)
- req_addr  in  NREQ*ADDR_W  packed target addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  pulses with ack when the granted address was ≥ DEPTH
- latch_en  out  DEPTH  one-hot latch enables; all zero outside the window
- latch_d  out  WIDTH  shared data bus to all latch D inputs
- busy  out  1  high in any state other than IDLE
- gnt_id  out  clog2(NREQ)  index of the current or most recent grant

## Operation
- All outputs are registered.
- Reset values: state = IDLE, ack = 0, err = 0, latch_en = 0, latch_d = 0, busy = 0, gnt_id = 0, round-robin pointer = 0.
- FSM states and transitions:
  - IDLE: if any req is high, pick the first high req at or after the pointer (wrapping). Capture its index, address and data, then go to SETUP. Otherwise stay in IDLE.
  - SETUP (1 cycle): latch_d = captured data; latch_en = 0.
  - OPEN (EN_CYCLES cycles): latch_en[addr] = 1. If addr ≥ DEPTH, latch_en stays 0.
  - HOLD (GUARD cycles): latch_en = 0; latch_d is unchanged.
  - ACK (1 cycle): ack[gnt_id] = 1 and err = (addr ≥ DEPTH). Pointer becomes (gnt_id+1) mod NREQ. Return to IDLE.
- latch_d holds its last value in IDLE. It changes only on entry to SETUP.
- Requesters hold req, addr and data stable until ack. Changes after the capture in IDLE are ignored.
- A req still high in the IDLE cycle after its ack counts as a new request.
- No preemption: requests arriving during a transaction wait for IDLE.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority.
- A request from the just-acked requester has lowest priority in the next arbitration.
- Reset mid-transaction: latch_en drops to 0 asynchronously and the transaction is abandoned with no ack. The partially written latch content is undefined.
- Invariants:
  - popcount(latch_en) ≤ 1 at all times.
  - latch_en is never high in the same cycle that latch_d changes.
  - Exactly one ack per grant.

## Timing
- Request sampled in IDLE at edge 0:
  - edge 0: enter SETUP
  - edge 1: enter OPEN
  - edge 1+EN_CYCLES: enter HOLD
  - edge 1+EN_CYCLES+GUARD: enter ACK (ack high this cycle)
  - edge 2+EN_CYCLES+GUARD: back in IDLE
- With defaults, ack is high in the cycle after edge 4, and latch_en is high for exactly 2 cycles, starting the cycle after edge 1.
- Minimum transaction period is 3+EN_CYCLES+GUARD cycles, including one IDLE cycle (6 with defaults).
- busy rises the cycle after edge 0 and falls when IDLE is re-entered.

## Test plan
- Single write: req[2] = 1, addr = 5, data = 0xA5. Expect latch_en = 8'b0010_0000 for 2 cycles, latch_d = 0xA5 one cycle before and GUARD cycles after the enable window, ack = 4'b0100 one cycle, err = 0, gnt_id = 2.
- Round-robin fairness: hold req = 4'b1111 continuously from reset. Expect grant order 0, 1, 2, 3, 0, with ack pulses every 6 cycles and exactly one ack bit per pulse.
- Pointer skip: pointer at 1 after serving 0, then req = 4'b1001. Expect grant 3 before 0.
- Out-of-range address: DEPTH = 6, addr = 7. Expect latch_en all zero throughout, then ack plus err = 1 in the same cycle.
- Reset mid-OPEN: assert rst while latch_en is high. Expect latch_en = 0 immediately with no clock edge, no ack, and after release busy = 0, pointer = 0, latch_d = 0.
- Protocol checker on all tests:
  - latch_en is one-hot or zero.
  - latch_d is stable whenever latch_en ≠ 0 and for GUARD cycles after it falls.
  - Input changes after capture do not affect latch_d.
